rv_regfile_mp: RTL and testbench
================================

Name: rv_regfile_mp

Overview:
Parametrised multi-read-port register file for the RV32I core, the successor of the single-cycle-reset 2-read/1-write file. Storage holds no reset, so it can map to RAM. A sequenced clear engine zeroes it after reset or on request. Adds a hardwired zero register, configurable read-port count and a per-register pending scoreboard for pipelined writeback hazard detection.

Parameters:
WIDTH, 32, data width of each register
DEPTH_BITS, 5, address width; DEPTH = 2**DEPTH_BITS entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is ordinary

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
ClrReq  in  1  pulse: start a clear sequence (accepted only in IDLE)
WrEn  in  1  write enable
WrAddress  in  DEPTH_BITS  write address
WrData  in  WIDTH  write data
PendSet  in  1  mark PendAddress as pending (issued instruction will write it)
PendAddress  in  DEPTH_BITS  register to mark pending
RdAddress  in  NUM_RD*DEPTH_BITS  packed read addresses, port k at [k*DEPTH_BITS +: DEPTH_BITS]
RdData  out  NUM_RD*WIDTH  packed read data, port k at [k*WIDTH +: WIDTH]
RdPending  out  NUM_RD  pending bit of each read port's addressed register
Busy  out  1  clear sequence in progress

Behaviour:
- Reset (RST low, async): FSM to CLEAR, clear pointer ptr = 0, pending bits all 0, Busy = 1. Storage array is not reset. While Busy = 1, RdData = 0 and RdPending = 0 on all ports.
- FSM states:
  - IDLE: normal operation. ClrReq = 1 goes to CLEAR with ptr = 0 and clears all pending bits on the same edge.
  - CLEAR: each cycle writes 0 to RF[ptr] and ptr++. When ptr == DEPTH-1 is written, go to IDLE, so Busy lasts exactly DEPTH cycles after reset release or ClrReq acceptance.
  - ClrReq during CLEAR is ignored; the sequence does not restart.
- Writes: in IDLE with WrEn = 1, RF[WrAddress] <= WrData at the rising edge. Writes in CLEAR are dropped.
- Zero register (ZERO_REG = 1): writes to address 0 are dropped; reads of address 0 return 0; PendSet to address 0 is ignored; RdPending for address 0 is always 0.
- Reads: combinational, RdData[k] = RF[RdAddress[k]], zero-latency. Without the optional feature, a same-cycle write is visible on the cycle after the edge.
- Pending scoreboard (IDLE only): one bit per entry.
  - PendSet sets bit[PendAddress]; WrEn clears bit[WrAddress].
  - Same edge, same address for both: set wins (new producer issued).
  - Different addresses: both take effect.
  - RdPending[k] = bit[RdAddress[k]], combinational.
- Reset mid-clear: restarts the sequence from ptr = 0.
- Width rules: ptr is DEPTH_BITS wide and the terminal compare is explicit, so there is no wrap past DEPTH-1.

Optional Feature:
Macro RF_WRITE_BYPASS_EN.
- Defined: in IDLE, if WrEn = 1 and RdAddress[k] == WrAddress (and is not the zero register when ZERO_REG = 1), RdData[k] = WrData in the same cycle and RdPending[k] = 0 unless PendSet targets the same address that cycle.
- Undefined: no forwarding. Reads return stored contents only, as specified above.

Test Plan:
- Release RST, hold ClrReq = 0: Busy = 1 for exactly 32 cycles, then 0. Afterwards every address reads 0 on all ports, including after array pre-load with 0xDEADBEEF via backdoor.
- IDLE, write 0x12345678 to x5, read x5 on port 0 and port 1 next cycle -> both return 0x12345678. Write 0xFFFFFFFF to x0 -> x0 still reads 0.
- PendSet x7, then 3 cycles later WrEn x7 = 0xA5A5A5A5: RdPending for x7 is 1 during those cycles and 0 after the write edge. PendSet and WrEn both on x9 in the same cycle -> RdPending x9 = 1 afterwards.
- Write x3 = 0x55 on cycle N with RdAddress0 = 3 on cycle N: RdData0 = old value (0) without RF_WRITE_BYPASS_EN, and 0x55 with it.
- ClrReq in IDLE after filling x1..x31 with nonzero data: Busy goes high, WrEn to x4 = 0x99 during CLEAR is dropped, pending bits clear. After 32 cycles all registers read 0. A second ClrReq mid-sequence does not extend Busy beyond 32 cycles.
- Assert RST at cycle 10 of a clear: Busy stays 1 and a full 32-cycle sequence restarts from ptr = 0 after release.

Source files
------------

// File: rtl/rv_regfile_mp_if.sv
// Bus bundle for the multi-port register file: write, pending-set,
// clear request and packed read ports.
interface rv_regfile_mp_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 5,
  parameter int NUM_RD     = 2
);
  logic                         ClrReq;
  logic                         WrEn;
  logic [DEPTH_BITS-1:0]        WrAddress;
  logic [WIDTH-1:0]             WrData;
  logic                         PendSet;
  logic [DEPTH_BITS-1:0]        PendAddress;
  logic [NUM_RD*DEPTH_BITS-1:0] RdAddress;
  logic [NUM_RD*WIDTH-1:0]      RdData;
  logic [NUM_RD-1:0]            RdPending;
  logic                         Busy;

  modport master (
    output ClrReq, WrEn, WrAddress, WrData,
    output PendSet, PendAddress, RdAddress,
    input  RdData, RdPending, Busy
  );

  modport slave (
    input  ClrReq, WrEn, WrAddress, WrData,
    input  PendSet, PendAddress, RdAddress,
    output RdData, RdPending, Busy
  );
endinterface

// File: rtl/rv_regfile_mp.sv
// Multi-read-port register file with clear engine and pending scoreboard.
// Optional same-cycle write forwarding: define RF_WRITE_BYPASS_EN.
module rv_regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input logic           CLK,
  input logic           RST,
  rv_regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] LAST = {DEPTH_BITS{1'b1}};

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] ptr_q, ptr_d;
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [WIDTH-1:0]      rf_q [DEPTH];

  logic                  mem_we;
  logic [DEPTH_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  idle;
  logic                  wr_ok;
  logic                  set_ok;

  assign idle = (state_q == S_IDLE);

  assign wr_ok = idle && bus.WrEn &&
    !((ZERO_REG != 0) && (bus.WrAddress == '0));

  assign set_ok = bus.PendSet &&
    !((ZERO_REG != 0) && (bus.PendAddress == '0));

  assign bus.Busy = (state_q == S_CLEAR);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_addr  = bus.WrAddress;
    mem_wdata = bus.WrData;
    unique case (1'b1)
      (state_q == S_CLEAR): begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST)
          state_d = S_IDLE;
      end
      (state_q == S_IDLE): begin
        mem_we = wr_ok;
        if (bus.ClrReq) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          pend_d  = '0;
        end else begin
          // Set is applied last so a new producer beats a retiring one
          if (bus.WrEn)
            pend_d[bus.WrAddress] = 1'b0;
          if (set_ok)
            pend_d[bus.PendAddress] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // No reset on storage so it can map onto RAM
  always_ff @(posedge CLK) begin
    if (mem_we)
      rf_q[mem_addr] <= mem_wdata;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DEPTH_BITS-1:0] ra;
    logic                  zr;
    logic [WIDTH-1:0]      rd_d;
    logic                  rd_p;

    assign ra = bus.RdAddress[k*DEPTH_BITS +: DEPTH_BITS];
    assign zr = (ZERO_REG != 0) && (ra == '0);

    always_comb begin
      rd_d = rf_q[ra];
      rd_p = pend_q[ra];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_ok && (ra == bus.WrAddress)) begin
        rd_d = bus.WrData;
        rd_p = set_ok && (bus.PendAddress == ra);
      end
`endif
      if (bus.Busy || zr) begin
        rd_d = '0;
        rd_p = 1'b0;
      end
    end

    assign bus.RdData[k*WIDTH +: WIDTH] = rd_d;
    assign bus.RdPending[k]             = rd_p;
  end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Directed bench for rv_regfile_mp with a cycle-level behavioural model
// and literal spot checks.
module tb_rv_regfile_mp;
  localparam int W  = 32;
  localparam int DB = 5;
  localparam int NR = 2;
  localparam int D  = 32;

`ifdef RF_WRITE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h55;
`else
  localparam logic [31:0] BYP_EXP = 32'h0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  rv_regfile_mp_if #(.WIDTH(W), .DEPTH_BITS(DB), .NUM_RD(NR)) bus ();

  rv_regfile_mp #(
    .WIDTH(W), .DEPTH_BITS(DB), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", n, got, exp, $time);
    end
  endtask

  // Model: register contents, pending set, remaining clear cycles
  logic [W-1:0] m_rf [D];
  logic [D-1:0] m_pend = '0;
  int           busy_left = D;

  function automatic logic [D-1:0] nxt_pend(
    input logic [D-1:0] p, input logic we, input logic [DB-1:0] wa,
    input logic ps, input logic [DB-1:0] pa);
    logic [D-1:0] r;
    r = p;
    if (we) r[wa] = 1'b0;
    if (ps && pa != 0) r[pa] = 1'b1;
    return r;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_left <= D;
      m_pend    <= '0;
    end else if (busy_left > 0) begin
      m_rf[D-busy_left] <= '0;
      busy_left         <= busy_left - 1;
    end else begin
      if (bus.WrEn && bus.WrAddress != 0)
        m_rf[bus.WrAddress] <= bus.WrData;
      if (bus.ClrReq) begin
        m_pend    <= '0;
        busy_left <= D;
      end else begin
        m_pend <= nxt_pend(m_pend, bus.WrEn, bus.WrAddress,
                           bus.PendSet, bus.PendAddress);
      end
    end
  end

  function automatic void exp_port(input logic [DB-1:0] a,
                                   output logic [W-1:0] d,
                                   output logic p);
    d = '0;
    p = 1'b0;
    if (busy_left == 0 && a != 0) begin
      d = m_rf[a];
      p = m_pend[a];
`ifdef RF_WRITE_BYPASS_EN
      if (bus.WrEn && bus.WrAddress == a) begin
        d = bus.WrData;
        p = bus.PendSet && bus.PendAddress == a;
      end
`endif
    end
  endfunction

  always @(negedge CLK) begin
    logic [W-1:0] ed;
    logic         ep;
    chk("busy", {31'b0, bus.Busy}, {31'b0, busy_left > 0});
    for (int k = 0; k < NR; k++) begin
      exp_port(bus.RdAddress[k*DB +: DB], ed, ep);
      chk("rd_data", bus.RdData[k*W +: W], ed);
      chk("rd_pend", {31'b0, bus.RdPending[k]}, {31'b0, ep});
    end
  end

  // Length of the most recent Busy run
  int run = 0;
  int last_run = 0;
  always @(negedge CLK or negedge RST) begin
    if (!RST) run <= 0;
    else if (bus.Busy) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.Busy && n < 200);
    #1;
    chk("idle_timeout", {31'b0, bus.Busy}, 32'h0);
    chk("busy_len", last_run, 32);
    tick();
  endtask

  task automatic wr(input logic [DB-1:0] a, input logic [W-1:0] d);
    bus.WrEn      = 1'b1;
    bus.WrAddress = a;
    bus.WrData    = d;
    tick();
    bus.WrEn = 1'b0;
  endtask

  task automatic rd(input logic [DB-1:0] a0, input logic [DB-1:0] a1);
    bus.RdAddress = {a1, a0};
    #1;
  endtask

  task automatic clr_pulse();
    bus.ClrReq = 1'b1;
    tick();
    bus.ClrReq = 1'b0;
  endtask

  task automatic all_zero(input string n);
    for (int i = 0; i < D; i++) begin
      rd(DB'(i), DB'(D - 1 - i));
      chk(n, bus.RdData[31:0], 32'h0);
      chk(n, bus.RdData[63:32], 32'h0);
      tick();
    end
  endtask

  initial begin
    bus.ClrReq      = 1'b0;
    bus.WrEn        = 1'b0;
    bus.WrAddress   = '0;
    bus.WrData      = '0;
    bus.PendSet     = 1'b0;
    bus.PendAddress = '0;
    bus.RdAddress   = '0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, bus.Busy}, 32'h1);
    RST = 1'b1;
    wait_idle();
    all_zero("post_rst_zero");

    for (int i = 0; i < D; i++) wr(DB'(i), 32'hDEADBEEF);
    rd(6, 0);
    chk("preload", bus.RdData[31:0], 32'hDEADBEEF);
    chk("preload_x0", bus.RdData[63:32], 32'h0);
    clr_pulse();
    wait_idle();
    all_zero("preload_clr");

    wr(5, 32'h12345678);
    rd(5, 5);
    chk("x5_p0", bus.RdData[31:0], 32'h12345678);
    chk("x5_p1", bus.RdData[63:32], 32'h12345678);
    wr(0, 32'hFFFFFFFF);
    rd(0, 0);
    chk("x0_zero", bus.RdData[31:0], 32'h0);

    bus.PendSet = 1'b1;
    bus.PendAddress = 7;
    tick();
    bus.PendSet = 1'b0;
    rd(7, 7);
    chk("x7_pend", {31'b0, bus.RdPending[0]}, 32'h1);
    tick();
    tick();
    chk("x7_pend3", {31'b0, bus.RdPending[1]}, 32'h1);
    wr(7, 32'hA5A5A5A5);
    chk("x7_pend_clr", {31'b0, bus.RdPending[0]}, 32'h0);
    chk("x7_data", bus.RdData[31:0], 32'hA5A5A5A5);

    bus.PendSet = 1'b1;
    bus.PendAddress = 9;
    wr(9, 32'h1);
    bus.PendSet = 1'b0;
    rd(9, 9);
    chk("x9_setwins", {31'b0, bus.RdPending[0]}, 32'h1);
    chk("x9_data", bus.RdData[63:32], 32'h1);

    rd(3, 0);
    bus.WrEn = 1'b1;
    bus.WrAddress = 3;
    bus.WrData = 32'h55;
    #1;
    chk("bypass", bus.RdData[31:0], BYP_EXP);
    tick();
    bus.WrEn = 1'b0;
    #1;
    chk("x3_after", bus.RdData[31:0], 32'h55);

    for (int i = 1; i < D; i++) wr(DB'(i), {8'(i), 24'hC0FFEE});
    bus.PendSet = 1'b1;
    bus.PendAddress = 10;
    tick();
    bus.PendSet = 1'b0;
    rd(10, 31);
    chk("x10_pend", {31'b0, bus.RdPending[0]}, 32'h1);
    chk("x31_fill", bus.RdData[63:32], 32'h1FC0FFEE);
    clr_pulse();
    chk("clr_busy", {31'b0, bus.Busy}, 32'h1);
    wr(4, 32'h99);
    repeat (8) tick();
    clr_pulse();
    wait_idle();
    rd(4, 10);
    chk("x4_dropped", bus.RdData[31:0], 32'h0);
    chk("x10_pend_clr", {31'b0, bus.RdPending[1]}, 32'h0);
    all_zero("clr_zero");

    for (int i = 1; i < D; i++) wr(DB'(i), 32'h0F0F0000 | i);
    clr_pulse();
    repeat (9) tick();
    RST = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, bus.Busy}, 32'h1);
    tick();
    tick();
    RST = 1'b1;
    wait_idle();
    all_zero("rst_mid_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
